// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: ownership states, default widths
// and the address-rejection helper.
package data_mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 14;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam logic [31:0] ALIGN_MASK     = 32'h0000_0003;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } own_state_e;

    // Misaligned byte address, or any bit above the word-index range set.
    function automatic logic addr_reject(input logic [31:0] addr, input int unsigned aw);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr & ALIGN_MASK) != 32'd0;
        out_of_range = (addr >> (aw + 32'd2)) != 32'd0;
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface data_mem_arbiter_if
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  req0;
    logic                  req1;
    logic                  writeEnable0;
    logic                  writeEnable1;
    logic [31:0]           address0;
    logic [31:0]           address1;
    logic [DATA_WIDTH-1:0] dataIn0;
    logic [DATA_WIDTH-1:0] dataIn1;
    logic                  lock0;
    logic                  lock1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] dataOut0;
    logic [DATA_WIDTH-1:0] dataOut1;
    logic                  err0;
    logic                  err1;
    logic [31:0]           memAddress;
    logic                  memWriteEnable;
    logic [DATA_WIDTH-1:0] memDataIn;
    logic [DATA_WIDTH-1:0] memDataOut;

    modport slave (
        input  req0, req1, writeEnable0, writeEnable1, address0, address1,
               dataIn0, dataIn1, lock0, lock1, memDataOut,
        output gnt0, gnt1, rvalid0, rvalid1, dataOut0, dataOut1, err0, err1,
               memAddress, memWriteEnable, memDataIn
    );

    modport master (
        output req0, req1, writeEnable0, writeEnable1, address0, address1,
               dataIn0, dataIn1, lock0, lock1, memDataOut,
        input  gnt0, gnt1, rvalid0, rvalid1, dataOut0, dataOut1, err0, err1,
               memAddress, memWriteEnable, memDataIn
    );
endinterface

// File: rtl/data_mem_arbiter_rr_pick.sv
// Two-requester round-robin pick honouring the ownership lock; one-hot result.
module data_mem_arbiter_rr_pick
    import data_mem_arbiter_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last_gnt,
    input  own_state_e i_state,
    output logic [1:0] o_gnt_c
);
    always_comb begin
        o_gnt_c = 2'b00;
        case (i_state)
            UNLOCKED: begin
                // On a tie the port not granted most recently wins.
                if (i_req0 && i_req1) o_gnt_c = i_last_gnt ? 2'b01 : 2'b10;
                else                  o_gnt_c = {i_req1, i_req0};
            end
            LOCKED0: o_gnt_c = {1'b0, i_req0};
            LOCKED1: o_gnt_c = {i_req1, 1'b0};
            default: o_gnt_c = 2'b00;
        endcase
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port between the CPU (port 0) and the debug/loader (port 1),
// with round-robin arbitration, an RMW lock and rejection of bad addresses.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
)(
    input  logic               clk,
    input  logic               reset,
    data_mem_arbiter_if.slave  bus
);
    own_state_e            r_state;
    logic                  r_last_gnt;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic                  r_err0;
    logic                  r_err1;
    logic [DATA_WIDTH-1:0] r_dout0;
    logic [DATA_WIDTH-1:0] r_dout1;

    logic [1:0]            w_pick;
    logic [1:0]            w_gnt;
    logic [31:0]           w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_we;
    logic                  w_lock;
    logic                  w_reject;

    data_mem_arbiter_rr_pick u_rr_pick (
        .i_req0     (bus.req0),
        .i_req1     (bus.req1),
        .i_last_gnt (r_last_gnt),
        .i_state    (r_state),
        .o_gnt_c    (w_pick)
    );

    // Granted-port mux; everything reads as idle while reset is high.
    always_comb begin
        w_gnt   = reset ? 2'b00 : w_pick;
        w_addr  = 32'd0;
        w_wdata = '0;
        w_we    = 1'b0;
        w_lock  = 1'b0;
        if (w_gnt[1]) begin
            w_addr  = bus.address1;
            w_wdata = bus.dataIn1;
            w_we    = bus.writeEnable1;
            w_lock  = bus.lock1;
        end else if (w_gnt[0]) begin
            w_addr  = bus.address0;
            w_wdata = bus.dataIn0;
            w_we    = bus.writeEnable0;
            w_lock  = bus.lock0;
        end
        w_reject = addr_reject(w_addr, ADDR_WIDTH);
    end

    assign bus.gnt0           = w_gnt[0];
    assign bus.gnt1           = w_gnt[1];
    assign bus.memAddress     = w_addr;
    assign bus.memDataIn      = w_wdata;
    assign bus.memWriteEnable = (|w_gnt) & w_we & ~w_reject & ~reset;

    assign bus.rvalid0  = r_rvalid0;
    assign bus.rvalid1  = r_rvalid1;
    assign bus.err0     = r_err0;
    assign bus.err1     = r_err1;
    assign bus.dataOut0 = r_dout0;
    assign bus.dataOut1 = r_dout1;

    // Ownership FSM and completion registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= UNLOCKED;
            r_last_gnt <= 1'b1;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_dout0    <= '0;
            r_dout1    <= '0;
        end else begin
            r_rvalid0 <= w_gnt[0];
            r_rvalid1 <= w_gnt[1];
            r_err0    <= w_gnt[0] & w_reject;
            r_err1    <= w_gnt[1] & w_reject;
            if (w_gnt[0]) begin
                if (w_reject)  r_dout0 <= '0;
                else if (!w_we) r_dout0 <= bus.memDataOut;
            end
            if (w_gnt[1]) begin
                if (w_reject)  r_dout1 <= '0;
                else if (!w_we) r_dout1 <= bus.memDataOut;
            end
            if (|w_gnt) begin
                r_last_gnt <= w_gnt[1];
                if (w_lock) r_state <= w_gnt[1] ? LOCKED1 : LOCKED0;
                else        r_state <= UNLOCKED;
            end
        end
    end
endmodule
